// File: rtl/lcd_fb_reader_if.sv
// Bundles the LCD-side pixel handshake and the SDRAM read port of lcd_fb_reader.
// master = the reader itself, slave = whatever drives it (SDRAM controller / LCD timing).
interface lcd_fb_reader_if;
    logic        en;
    logic        iFrame_Start;
    logic        iPixel_Req;
    logic [15:0] oPixel_Data;
    logic        oPixel_Valid;
    logic        oUnderrun;
    logic [23:0] oSDRAM_Rd_Addr;
    logic        oSDRAM_Rd_Req;
    logic [15:0] iSDRAM_Rd_Data1;
    logic [15:0] iSDRAM_Rd_Data2;
    logic [15:0] iSDRAM_Rd_Data3;
    logic [15:0] iSDRAM_Rd_Data4;
    logic        iSDRAM_Rd_Done;
    logic        oFrame_Done;

    modport master (
        input  en, iFrame_Start, iPixel_Req,
        input  iSDRAM_Rd_Data1, iSDRAM_Rd_Data2, iSDRAM_Rd_Data3, iSDRAM_Rd_Data4, iSDRAM_Rd_Done,
        output oPixel_Data, oPixel_Valid, oUnderrun, oSDRAM_Rd_Addr, oSDRAM_Rd_Req, oFrame_Done
    );

    modport slave (
        output en, iFrame_Start, iPixel_Req,
        output iSDRAM_Rd_Data1, iSDRAM_Rd_Data2, iSDRAM_Rd_Data3, iSDRAM_Rd_Data4, iSDRAM_Rd_Done,
        input  oPixel_Data, oPixel_Valid, oUnderrun, oSDRAM_Rd_Addr, oSDRAM_Rd_Req, oFrame_Done
    );
endinterface

// File: rtl/lcd_fb_reader.sv
// Framebuffer reader: 4-word SDRAM bursts into a pixel FIFO, one pixel per LCD request (1-cycle latency).
// Bursts are only requested when the FIFO has room for all 4 words; an empty FIFO returns UNDERRUN_COLOR.
module lcd_fb_reader #(
    parameter int          H_PIXELS       = 480,
    parameter int          V_LINES        = 272,
    parameter logic [23:0] BASE_ADDR      = 24'h000000,
    parameter int          FIFO_DEPTH     = 16,
    parameter logic [15:0] UNDERRUN_COLOR = 16'h0000
) (
    input  logic             clk,
    input  logic             rst_n,
    lcd_fb_reader_if.master  bus
);
    localparam int TOTAL = H_PIXELS * V_LINES / 4;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam logic [CW-1:0]    SPACE_MAX = CW'(FIFO_DEPTH - 4);
    localparam logic [CNT_W-1:0] CNT_END   = CNT_W'(TOTAL);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_DRAIN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]      fill_q, fill_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic               req_q, req_d;
    logic [23:0]        addr_q, addr_d;
    logic [15:0]        pix_dat_q, pix_dat_d;
    logic               pix_vld_q, pix_vld_d;
    logic               underrun_q, underrun_d;
    logic               frame_done_q, frame_done_d;
    logic               push, pop, flush;
    logic [15:0]        mem_q [FIFO_DEPTH];
    logic [15:0]        burst [4];

    assign burst[0] = bus.iSDRAM_Rd_Data1;
    assign burst[1] = bus.iSDRAM_Rd_Data2;
    assign burst[2] = bus.iSDRAM_Rd_Data3;
    assign burst[3] = bus.iSDRAM_Rd_Data4;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        addr_d       = addr_q;
        frame_done_d = 1'b0;
        push         = 1'b0;
        flush        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.iFrame_Start) begin
                    flush   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (bus.iFrame_Start) begin
                    flush = 1'b1;
                    cnt_d = '0;
                end else if (cnt_q == CNT_END) begin
                    frame_done_d = 1'b1;
                    state_d      = S_IDLE;
                end else if (bus.en && (fill_q <= SPACE_MAX)) begin
                    req_d   = 1'b1;
                    addr_d  = BASE_ADDR + (24'(cnt_q) << 2);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.iSDRAM_Rd_Done) begin
                    req_d   = 1'b0;
                    state_d = S_FETCH;
                    if (bus.iFrame_Start) begin
                        flush = 1'b1;
                        cnt_d = '0;
                    end else begin
                        push  = 1'b1;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (bus.iFrame_Start) begin
                    // SDRAM bursts cannot be aborted: keep the request up and discard the data later.
                    flush   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                flush = bus.iFrame_Start;
                if (bus.iSDRAM_Rd_Done) begin
                    req_d   = 1'b0;
                    flush   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        pop        = bus.iPixel_Req && (fill_q != '0) && !flush;
        pix_vld_d  = bus.iPixel_Req;
        pix_dat_d  = pix_dat_q;
        if (pop) begin
            pix_dat_d = mem_q[rd_ptr_q];
        end else if (bus.iPixel_Req) begin
            pix_dat_d = UNDERRUN_COLOR;
        end
        underrun_d = bus.iFrame_Start ? 1'b0 : (underrun_q | (bus.iPixel_Req & !pop));

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + AW'(pop);
            wr_ptr_d = wr_ptr_q + (push ? AW'(4) : AW'(0));
            fill_d   = fill_q + (push ? CW'(4) : CW'(0)) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            fill_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            req_q        <= 1'b0;
            addr_q       <= BASE_ADDR;
            pix_dat_q    <= '0;
            pix_vld_q    <= 1'b0;
            underrun_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fill_q       <= fill_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            pix_dat_q    <= pix_dat_d;
            pix_vld_q    <= pix_vld_d;
            underrun_q   <= underrun_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            for (int i = 0; i < 4; i++) begin
                mem_q[wr_ptr_q + AW'(i)] <= burst[i];
            end
        end
    end

    assign bus.oPixel_Data    = pix_dat_q;
    assign bus.oPixel_Valid   = pix_vld_q;
    assign bus.oUnderrun      = underrun_q;
    assign bus.oSDRAM_Rd_Addr = addr_q;
    assign bus.oSDRAM_Rd_Req  = req_q;
    assign bus.oFrame_Done    = frame_done_q;
endmodule

// File: tb/tb_lcd_fb_reader.sv
// Scoreboard bench for lcd_fb_reader with a small frame (16x2 pixels = 8 bursts) and a 5-cycle SDRAM model.
module tb_lcd_fb_reader;
    localparam int          H     = 16;
    localparam int          V     = 2;
    localparam int          TOTAL = H * V / 4;
    localparam int          BASE  = 0;
    localparam logic [15:0] UND   = 16'hF81F;
    localparam int          LAT   = 5;

    logic clk;
    logic rst_n;
    logic px_a, px_b;
    lcd_fb_reader_if bus ();

    lcd_fb_reader #(
        .H_PIXELS(H), .V_LINES(V), .BASE_ADDR(24'(BASE)), .FIFO_DEPTH(16), .UNDERRUN_COLOR(UND)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    assign bus.iPixel_Req = px_a | px_b;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_q[$];
    logic        exp_vld, exp_un, exp_fd, fd_pend, discard, chk_en, pop_on_done;
    logic [15:0] exp_dat;
    int          nb, req_cnt, fd_cnt;
    logic        busy, done_sent;
    int          lat_cnt, sd_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [15:0] word(input int a, input int j);
        return 16'((j + 1) * 'h1111) ^ 16'(a * 'h0101);
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SDRAM model: answers each request LAT cycles later and checks request/address handling.
    initial begin
        busy = 0; done_sent = 0; lat_cnt = 0; sd_addr = 0; req_cnt = 0; px_b = 0;
        bus.iSDRAM_Rd_Done = 0;
        bus.iSDRAM_Rd_Data1 = 0; bus.iSDRAM_Rd_Data2 = 0;
        bus.iSDRAM_Rd_Data3 = 0; bus.iSDRAM_Rd_Data4 = 0;
        forever begin
            @(negedge clk);
            bus.iSDRAM_Rd_Done = 0;
            px_b = 0;
            if (!rst_n) begin
                busy = 0; done_sent = 0;
            end else if (busy) begin
                if (done_sent) begin
                    check("req_drop", 32'(bus.oSDRAM_Rd_Req), 0);
                    busy = 0; done_sent = 0;
                end else begin
                    check("req_hold", 32'(bus.oSDRAM_Rd_Req), 1);
                    check("addr_hold", 32'(bus.oSDRAM_Rd_Addr), 32'(sd_addr));
                    lat_cnt++;
                    if (lat_cnt == LAT) begin
                        bus.iSDRAM_Rd_Data1 = word(sd_addr, 0);
                        bus.iSDRAM_Rd_Data2 = word(sd_addr, 1);
                        bus.iSDRAM_Rd_Data3 = word(sd_addr, 2);
                        bus.iSDRAM_Rd_Data4 = word(sd_addr, 3);
                        bus.iSDRAM_Rd_Done  = 1;
                        done_sent = 1;
                        px_b = pop_on_done;
                    end
                end
            end else if (bus.oSDRAM_Rd_Req) begin
                busy = 1; lat_cnt = 1; req_cnt++;
                sd_addr = BASE + 4 * nb;
                check("rd_addr", 32'(bus.oSDRAM_Rd_Addr), 32'(sd_addr));
            end
        end
    end

    // Scoreboard update on the edge where the DUT samples its inputs.
    initial begin
        logic fs, pr, dn, accept;
        nb = 0; discard = 0; exp_vld = 0; exp_un = 0; exp_fd = 0; fd_pend = 0; exp_dat = 0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                exp_q.delete();
                nb = 0; discard = 0; exp_vld = 0; exp_un = 0; exp_fd = 0; fd_pend = 0; exp_dat = 0;
            end else begin
                fs = bus.iFrame_Start; pr = bus.iPixel_Req; dn = bus.iSDRAM_Rd_Done;
                exp_fd  = fd_pend && !fs;
                fd_pend = 0;
                accept  = 0;
                if (dn) begin
                    accept  = !fs && !discard;
                    discard = 0;
                end else if (fs && busy) begin
                    discard = 1;
                end
                exp_vld = pr;
                if (fs) begin
                    exp_q.delete();
                    exp_un = 0;
                    nb = 0;
                    if (pr) exp_dat = UND;
                end else if (pr) begin
                    if (exp_q.size() > 0) exp_dat = exp_q.pop_front();
                    else begin
                        exp_dat = UND;
                        exp_un  = 1;
                    end
                end
                if (accept) begin
                    for (int j = 0; j < 4; j++) exp_q.push_back(word(BASE + 4 * nb, j));
                    nb++;
                    if (nb == TOTAL) fd_pend = 1;
                end
            end
        end
    end

    // Per-cycle output comparison against the scoreboard.
    initial begin
        fd_cnt = 0;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("pix_vld", 32'(bus.oPixel_Valid), 32'(exp_vld));
                check("pix_dat", 32'(bus.oPixel_Data), 32'(exp_dat));
                check("underrun", 32'(bus.oUnderrun), 32'(exp_un));
                check("frame_done", 32'(bus.oFrame_Done), 32'(exp_fd));
                if (bus.oFrame_Done) fd_cnt++;
            end
        end
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_fs();
        bus.iFrame_Start = 1;
        @(negedge clk);
        bus.iFrame_Start = 0;
    endtask

    task automatic pop_one();
        px_a = 1;
        @(negedge clk);
        px_a = 0;
    endtask

    task automatic consume(input int n);
        for (int i = 0; i < n; i++) begin
            px_a = (exp_q.size() > 0);
            @(negedge clk);
        end
        px_a = 0;
    endtask

    initial begin
        int r0, fd0;
        chk_en = 0; pop_on_done = 0; px_a = 0; rst_n = 0;
        bus.en = 0; bus.iFrame_Start = 0;
        cycles(3);
        check("rst_vld", 32'(bus.oPixel_Valid), 0);
        check("rst_dat", 32'(bus.oPixel_Data), 0);
        check("rst_underrun", 32'(bus.oUnderrun), 0);
        check("rst_req", 32'(bus.oSDRAM_Rd_Req), 0);
        check("rst_addr", 32'(bus.oSDRAM_Rd_Addr), 32'(BASE));
        check("rst_fdone", 32'(bus.oFrame_Done), 0);
        rst_n = 1; bus.en = 1; chk_en = 1;
        cycles(5);
        check("idle_no_req", 32'(req_cnt), 0);

        // First frame: two bursts, then four pixels in order.
        pulse_fs();
        for (int i = 0; i < 100 && req_cnt < 2; i++) @(negedge clk);
        check("two_reqs", 32'(req_cnt), 2);
        px_a = 1;
        cycles(4);
        px_a = 0;

        // No consumption: FIFO fills and fetching stalls.
        cycles(100);
        check("stall_reqs", 32'(req_cnt), 5);
        check("stall_req_low", 32'(bus.oSDRAM_Rd_Req), 0);
        for (int i = 0; i < 600 && fd_cnt < 1; i++) begin
            px_a = (exp_q.size() > 0);
            @(negedge clk);
        end
        px_a = 0;
        check("fdone_once", 32'(fd_cnt), 1);
        check("frame_reqs", 32'(req_cnt), TOTAL);
        consume(40);
        check("idle_reqs", 32'(req_cnt), TOTAL);
        check("fdone_total", 32'(fd_cnt), 1);

        // Continuous requests from frame start: flush wins, then underrun.
        bus.iFrame_Start = 1; px_a = 1;
        @(negedge clk);
        bus.iFrame_Start = 0;
        cycles(30);
        check("underrun_set", 32'(bus.oUnderrun), 1);
        px_a = 0;
        @(negedge clk);
        pulse_fs();
        check("underrun_clr", 32'(bus.oUnderrun), 0);

        // Frame restart while the third burst is outstanding.
        for (int i = 0; i < 300 && !(nb == 2 && bus.oSDRAM_Rd_Req && busy); i++) @(negedge clk);
        check("third_req_seen", 32'(nb == 2 && bus.oSDRAM_Rd_Req), 1);
        fd0 = fd_cnt;
        r0  = req_cnt;
        pulse_fs();
        for (int i = 0; i < 100 && req_cnt < r0 + 1; i++) @(negedge clk);
        check("req_after_drain", 32'(req_cnt), 32'(r0 + 1));
        check("drain_no_fdone", 32'(fd_cnt), 32'(fd0));

        // en dropped while the burst is outstanding.
        bus.en = 0;
        r0 = req_cnt;
        consume(40);
        check("en0_no_req", 32'(req_cnt), 32'(r0));
        bus.en = 1;
        for (int i = 0; i < 40 && req_cnt < r0 + 1; i++) @(negedge clk);
        check("en1_req", 32'(req_cnt), 32'(r0 + 1));

        // Done push coincident with a pop at fill 12.
        consume(20);
        pulse_fs();
        for (int i = 0; i < 300 && !(exp_q.size() == 12 && nb == 3 && bus.oSDRAM_Rd_Req); i++) @(negedge clk);
        check("fill12_req", 32'(exp_q.size() == 12 && bus.oSDRAM_Rd_Req), 1);
        pop_on_done = 1;
        for (int i = 0; i < 40 && bus.oSDRAM_Rd_Req; i++) @(negedge clk);
        pop_on_done = 0;
        r0 = req_cnt;
        cycles(20);
        check("withheld_15", 32'(req_cnt), 32'(r0));
        pop_one(); cycles(5);
        pop_one(); cycles(5);
        check("withheld_13", 32'(req_cnt), 32'(r0));
        pop_one();
        for (int i = 0; i < 20 && req_cnt < r0 + 1; i++) @(negedge clk);
        check("resume_12", 32'(req_cnt), 32'(r0 + 1));
        cycles(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
